// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Queues JK drive commands in a small FIFO and plays them out, one after the
// other, onto the registered j/k outputs that feed a downstream JK flip-flop.
// Each command holds {j,k} = cmd_op for cmd_len+1 consecutive cycles. Commands
// run back-to-back with no idle cycle between them while the FIFO has work.
//
// Optional feature (macro JK_SEQ_MODEL_EN):
//   defined   - q_model predicts the downstream flop's q from the registered
//               j/k, and err latches any disagreement with q_fb until reset.
//   undefined - q_model and err are tied low and q_fb is ignored.
//
// Parameters
//   DEPTH  command FIFO depth in entries (power of two, 2..16)
//   CNT_W  width of the per-command repeat length
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  upstream offers a command
//   cmd_ready  FIFO has room (count < DEPTH)
//   cmd_op     2-bit op: 00 hold, 01 clear, 10 set, 11 toggle ({j,k})
//   cmd_len    drive cycles minus one
//   flush      synchronous abort of queued and active commands
//   j, k       registered JK drive
//   busy       a command is being driven
//   done       high during the last drive cycle of a command
//   q_fb       q fed back from the downstream flop
//   q_model    predicted downstream q
//   err        sticky q_fb / q_model mismatch
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             flush,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    input  logic             q_fb,
    output logic             q_model,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = CNT_W + 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Command storage: {op, len}
    logic [EW-1:0]    fifo_mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;

    state_t           state;
    state_t           state_nxt;
    logic             j_nxt;
    logic             k_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             last_cycle;
    logic [EW-1:0]    head_entry;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    assign head_entry = fifo_mem[head];
    assign head_op    = head_entry[EW-1:CNT_W];
    assign head_len   = head_entry[CNT_W-1:0];

    assign cmd_ready  = (count < CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign last_cycle = (state == DRIVE) && (cnt == '0);

    // flush wins over any push offered on the same edge.
    assign push = cmd_valid && cmd_ready && !flush;
    // The head is consumed when idle, or on the final cycle of the active
    // command so the next one starts without a gap.
    assign pop  = !flush && !fifo_empty && ((state == IDLE) || last_cycle);

    assign busy = (state == DRIVE);
    assign done = last_cycle && !flush;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is pure data: no reset needed, occupancy says what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= {cmd_op, cmd_len};
    end

    // FSM state and drive registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        j_nxt     = j;
        k_nxt     = k;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            j_nxt     = 1'b0;
            k_nxt     = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state_nxt      = DRIVE;
                        {j_nxt, k_nxt} = head_op;
                        cnt_nxt        = head_len;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (pop) begin
                        {j_nxt, k_nxt} = head_op;
                        cnt_nxt        = head_len;
                    end else begin
                        state_nxt = IDLE;
                        j_nxt     = 1'b0;
                        k_nxt     = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    j_nxt     = 1'b0;
                    k_nxt     = 1'b0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef JK_SEQ_MODEL_EN
    function automatic logic jk_next(input logic q, input logic jj, input logic kk);
        case ({jj, kk})
            2'b00:   jk_next = q;
            2'b01:   jk_next = 1'b0;
            2'b10:   jk_next = 1'b1;
            default: jk_next = ~q;
        endcase
    endfunction

    // The downstream flop samples the same registered j/k on the same edge,
    // so comparing before the update lines both copies up cycle for cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_model <= 1'b0;
            err     <= 1'b0;
        end else begin
            q_model <= jk_next(q_model, j, k);
            err     <= err | (q_fb != q_model);
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign q_model     = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
